vga_scan_driver: RTL

- Generates 640x480@60 VGA raster timing and drives the pixel coordinate bus (x, y) consumed by the animator.
- Takes back the animator's r/g/b, aligns them with delayed sync/blank, and drives the DAC/connector pins.
- Emits per-frame strobes used by game logic (obstacle scroll, Barry physics) to update once per frame during vertical blank.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_scan_driver_if.sv | 31 +++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_scan_driver.sv | 119 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and packed types for the VGA scan driver.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int CLK_DIV    = 2;
    localparam int RENDER_LAT = 2;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_t;

    // Half-open window test used for the sync pulses: lo <= val < hi.
    function automatic logic inWindow(input logic [9:0] val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) < hi);
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Pixel coordinate / colour / pin bundle between the scan driver and its consumers.
interface vga_scan_driver_if;

    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_pix_en;
    logic       frame_start;
    logic       vblank_start;

    modport master (
        output x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               vga_pix_en, frame_start, vblank_start,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               vga_pix_en, frame_start, vblank_start,
        output r_in, g_in, b_in
    );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; every stage resets to a caller-supplied idle value.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: pixel divider, h/v counters, x/y bus, latency-matched sync and colour pins.
module vga_scan_driver #(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int CLK_DIV    = vga_pkg::CLK_DIV,
    parameter int RENDER_LAT = vga_pkg::RENDER_LAT
) (
    input  logic              clk,
    input  logic              reset,
    vga_scan_driver_if.master bus
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam vga_pkg::sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    generate
        if (CLK_DIV < 1 || CLK_DIV > 4 || RENDER_LAT < 1 || RENDER_LAT > 4 ||
            H_TOTAL > 1024 || V_TOTAL > 1024 || V_ACTIVE > 512) begin : g_param_check
            $fatal(1, "vga_scan_driver: illegal parameter set");
        end
    endgenerate

    logic [1:0]     div_q, div_d;
    logic [9:0]     h_q, h_d, v_q, v_d;
    logic           pixEn, hWrap, vWrap;
    vga_pkg::sync_t syncRaw, syncDly;
    vga_pkg::rgb_t  colourIn, rgb_q;
    logic [9:0]     x_q;
    logic [8:0]     y_q;
    logic           hs_q, vs_q, blankN_q, pixEn_q, frameStart_q, vblankStart_q;

    always_comb begin
        pixEn   = (div_q == 2'(CLK_DIV - 1));
        hWrap   = (h_q == 10'(H_TOTAL - 1));
        vWrap   = (v_q == 10'(V_TOTAL - 1));
        div_d   = pixEn ? 2'd0 : div_q + 2'd1;
        h_d     = h_q;
        v_d     = v_q;
        if (pixEn) begin
            h_d = hWrap ? 10'd0 : h_q + 10'd1;
            if (hWrap) v_d = vWrap ? 10'd0 : v_q + 10'd1;
        end
        syncRaw.hs     = ~vga_pkg::inWindow(h_q, HS_START, HS_END);
        syncRaw.vs     = ~vga_pkg::inWindow(v_q, VS_START, VS_END);
        syncRaw.active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        colourIn       = {bus.r_in, bus.g_in, bus.b_in};
    end

    // Sync/active ride a pipeline as deep as the animator so they reach the pins with the colour.
    vga_delay_line #(
        .DEPTH(RENDER_LAT),
        .WIDTH($bits(vga_pkg::sync_t))
    ) u_sync_dly (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (pixEn),
        .rst_val_i(SYNC_IDLE),
        .d_i      (syncRaw),
        .q_o      (syncDly)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= 2'd0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blankN_q      <= 1'b0;
            pixEn_q       <= 1'b0;
            frameStart_q  <= 1'b0;
            vblankStart_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pixEn_q       <= pixEn;
            frameStart_q  <= 1'b0;
            vblankStart_q <= 1'b0;
            if (pixEn) begin
                x_q           <= (int'(h_q) < H_ACTIVE) ? h_q : 10'd0;
                y_q           <= (int'(v_q) < V_ACTIVE) ? v_q[8:0] : 9'd0;
                frameStart_q  <= (h_q == 10'd0) && (v_q == 10'd0);
                vblankStart_q <= (h_q == 10'd0) && (v_q == 10'(V_ACTIVE));
                rgb_q         <= syncDly.active ? colourIn : '0;
                hs_q          <= syncDly.hs;
                vs_q          <= syncDly.vs;
                blankN_q      <= syncDly.active;
            end
        end
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.vga_r        = rgb_q.r;
    assign bus.vga_g        = rgb_q.g;
    assign bus.vga_b        = rgb_q.b;
    assign bus.vga_hs       = hs_q;
    assign bus.vga_vs       = vs_q;
    assign bus.vga_blank_n  = blankN_q;
    assign bus.vga_pix_en   = pixEn_q;
    assign bus.frame_start  = frameStart_q;
    assign bus.vblank_start = vblankStart_q;

endmodule
